// File: rtl/result_writer_pkg.sv
// result_writer_pkg: shared types and constants for the result writer.
//   state_t  - writer FSM states (IDLE, WRITE, FINISH)
//   column_t - one result column, element 0 holds MU1
//   zext_mu  - zero-extends one mul-sum result to a RAM word
package result_writer_pkg;

    localparam int unsigned MU_W   = 18;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BEATS  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        FINISH = 2'd2
    } state_t;

    typedef logic [BEATS-1:0][MU_W-1:0] column_t;

    function automatic logic [DATA_W-1:0] zext_mu(input logic [MU_W-1:0] v);
        return {{(DATA_W - MU_W){1'b0}}, v};
    endfunction

endpackage

// File: rtl/result_buf.sv
// result_buf: one buffered result column (4 x MU_W) with last-column flag and valid bit.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   load_i    - capture mu_i/last_i and mark valid (wins over clear_i)
//   clear_i   - mark buffer empty
//   mu_i      - column to capture, element 0 = MU1
//   last_i    - column is the last of its matrix
//   mu_o, last_o, valid_o - stored column, flag and occupancy
module result_buf
    import result_writer_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    load_i,
    input  logic    clear_i,
    input  column_t mu_i,
    input  logic    last_i,
    output column_t mu_o,
    output logic    last_o,
    output logic    valid_o
);

    column_t mu_q, mu_d;
    logic    last_q, last_d;
    logic    valid_q, valid_d;

    always_comb begin
        mu_d    = mu_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (load_i) begin
            mu_d    = mu_i;
            last_d  = last_i;
            valid_d = 1'b1;
        end else if (clear_i) begin
            last_d  = 1'b0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mu_q    <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            mu_q    <= mu_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign mu_o    = mu_q;
    assign last_o  = last_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/result_writer.sv
// result_writer: streams 4-word result columns from the mul-sum units into a 64-word RAM.
// Each web_in column is written as four consecutive registered RAM beats (MU1..MU4) at
// incrementing addresses. One extra column can be held in a pending buffer while the active
// one is written; a column arriving with pending full is dropped and flagged.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   start               - in IDLE: clear address, overrun, wrap (and sat_flag)
//   web_in              - MU1..MU4 hold a finished column
//   MU1..MU4            - 18-bit unsigned results
//   ALU_done_in         - current web_in column is the last of the matrix
//   ram_en/ram_we/ram_addr/ram_wdata - registered RAM write port
//   busy                - writing, finishing, or a column is pending
//   wr_done             - one-cycle pulse after the last column of a matrix
//   overrun, wrap       - sticky: column lost / address wrapped 63 -> 0
//   sat_flag            - sticky clamp indicator (only with RESULT_SAT_EN)
// Build option: define RESULT_SAT_EN to clamp values above 16'hFFFF to 32'h0000FFFF.
module result_writer
    import result_writer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              web_in,
    input  logic [MU_W-1:0]   MU1,
    input  logic [MU_W-1:0]   MU2,
    input  logic [MU_W-1:0]   MU3,
    input  logic [MU_W-1:0]   MU4,
    input  logic              ALU_done_in,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              busy,
    output logic              wr_done,
    output logic              overrun,
`ifdef RESULT_SAT_EN
    output logic              sat_flag,
`endif
    output logic              wrap
);

    state_t            state_q, state_d;
    logic [1:0]        beat_q, beat_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ram_en_q, ram_we_q, ram_we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wr_done_q, wr_done_d;
    logic              overrun_q, overrun_d;
    logic              wrap_q, wrap_d;
`ifdef RESULT_SAT_EN
    logic              sat_q, sat_d;
`endif

    column_t in_col;
    column_t act_mu, pend_mu, act_in;
    logic    act_last, act_valid, pend_last, pend_valid;
    logic    act_load_in, pend_move, act_clear, pend_load;
    logic    launch;
    logic [MU_W-1:0] sel_mu;

    assign in_col = {MU4, MU3, MU2, MU1};
    assign act_in = act_load_in ? in_col : pend_mu;

    result_buf u_active (
        .clk     (clk),
        .rst     (rst),
        .load_i  (act_load_in | pend_move),
        .clear_i (act_clear),
        .mu_i    (act_in),
        .last_i  (act_load_in ? ALU_done_in : pend_last),
        .mu_o    (act_mu),
        .last_o  (act_last),
        .valid_o (act_valid)
    );

    result_buf u_pending (
        .clk     (clk),
        .rst     (rst),
        .load_i  (pend_load),
        .clear_i (pend_move),
        .mu_i    (in_col),
        .last_i  (ALU_done_in),
        .mu_o    (pend_mu),
        .last_o  (pend_last),
        .valid_o (pend_valid)
    );

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        addr_d      = addr_q;
        overrun_d   = overrun_q;
        wrap_d      = wrap_q;
        act_load_in = 1'b0;
        pend_move   = 1'b0;
        act_clear   = 1'b0;
        launch      = 1'b0;
        sel_mu      = '0;
`ifdef RESULT_SAT_EN
        sat_d       = sat_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d    = '0;
                    overrun_d = 1'b0;
                    wrap_d    = 1'b0;
`ifdef RESULT_SAT_EN
                    sat_d     = 1'b0;
`endif
                end
                // A column captured on the last WRITE beat waits in pending; drain it first.
                if (pend_valid) begin
                    pend_move = 1'b1;
                    launch    = 1'b1;
                    sel_mu    = pend_mu[0];
                    state_d   = WRITE;
                    beat_d    = '0;
                end else if (web_in) begin
                    act_load_in = 1'b1;
                    launch      = 1'b1;
                    sel_mu      = MU1;
                    state_d     = WRITE;
                    beat_d      = '0;
                end
            end
            WRITE: begin
                addr_d = addr_q + ADDR_W'(1);
                if (addr_q == {ADDR_W{1'b1}}) begin
                    wrap_d = 1'b1;
                end
                if (beat_q != 2'(BEATS - 1)) begin
                    beat_d = beat_q + 2'd1;
                    launch = 1'b1;
                    sel_mu = act_mu[beat_q + 2'd1];
                end else if (pend_valid) begin
                    pend_move = 1'b1;
                    launch    = 1'b1;
                    sel_mu    = pend_mu[0];
                    beat_d    = '0;
                end else begin
                    act_clear = 1'b1;
                    beat_d    = '0;
                    state_d   = (act_valid && act_last) ? FINISH : IDLE;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outside an empty-pending IDLE, new columns go to pending if it is free at this edge.
        pend_load = web_in && !pend_valid && (state_q != IDLE);
        if (web_in && pend_valid) begin
            overrun_d = 1'b1;
        end

        ram_we_d  = launch;
        wdata_d   = wdata_q;
        if (launch) begin
            wdata_d = zext_mu(sel_mu);
`ifdef RESULT_SAT_EN
            if (|sel_mu[MU_W-1:16]) begin
                wdata_d = 32'h0000FFFF;
                sat_d   = 1'b1;
            end
`endif
        end
        wr_done_d = (state_d == FINISH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            addr_q    <= '0;
            ram_en_q  <= 1'b0;
            ram_we_q  <= 1'b0;
            wdata_q   <= '0;
            wr_done_q <= 1'b0;
            overrun_q <= 1'b0;
            wrap_q    <= 1'b0;
`ifdef RESULT_SAT_EN
            sat_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            addr_q    <= addr_d;
            ram_en_q  <= ram_we_d;
            ram_we_q  <= ram_we_d;
            wdata_q   <= wdata_d;
            wr_done_q <= wr_done_d;
            overrun_q <= overrun_d;
            wrap_q    <= wrap_d;
`ifdef RESULT_SAT_EN
            sat_q     <= sat_d;
`endif
        end
    end

    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign busy      = (state_q != IDLE) || pend_valid;
    assign wr_done   = wr_done_q;
    assign overrun   = overrun_q;
    assign wrap      = wrap_q;
`ifdef RESULT_SAT_EN
    assign sat_flag  = sat_q;
`endif

endmodule
